alarm_msg_display: RTL

//  Parametrised N-digit 7-segment message engine for the alarm front panel.

---
 rtl/alarm_disp_pkg.sv | 59 +++++
 rtl/alarm_msg_display_seg7_char_dec.sv | 14 +
 rtl/alarm_msg_display.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/alarm_disp_pkg.sv
// Shared definitions for the alarm front-panel message engine:
// character codes, mode and state encodings, and the segment table.
package alarm_disp_pkg;

  typedef logic [4:0] char_t;

  // Character codes 0..9 are the decimal digits themselves.
  localparam char_t CH_A     = 5'd10;
  localparam char_t CH_E     = 5'd11;
  localparam char_t CH_H     = 5'd12;
  localparam char_t CH_L     = 5'd13;
  localparam char_t CH_O     = 5'd14;
  localparam char_t CH_P     = 5'd15;
  localparam char_t CH_U     = 5'd16;
  localparam char_t CH_R     = 5'd17;
  localparam char_t CH_DASH  = 5'd18;
  localparam char_t CH_BLANK = 5'h1F;

  // Display modes; 2'b11 behaves as static.
  localparam logic [1:0] MODE_STATIC = 2'b00;
  localparam logic [1:0] MODE_BLINK  = 2'b01;
  localparam logic [1:0] MODE_SCROLL = 2'b10;

  // FSM states.
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SHOW_ON  = 2'd1;
  localparam logic [1:0] ST_SHOW_OFF = 2'd2;
  localparam logic [1:0] ST_SCROLL   = 2'd3;

  // Active-high segment pattern, bit 0 = a ... bit 6 = g.
  // Codes without a glyph decode as blank.
  function automatic logic [6:0] char_segments(input char_t code);
    logic [6:0] pat;
    case (code)
      5'd0:     pat = 7'h3F;
      5'd1:     pat = 7'h06;
      5'd2:     pat = 7'h5B;
      5'd3:     pat = 7'h4F;
      5'd4:     pat = 7'h66;
      5'd5:     pat = 7'h6D;
      5'd6:     pat = 7'h7D;
      5'd7:     pat = 7'h07;
      5'd8:     pat = 7'h7F;
      5'd9:     pat = 7'h6F;
      CH_A:     pat = 7'h77;
      CH_E:     pat = 7'h79;
      CH_H:     pat = 7'h76;
      CH_L:     pat = 7'h38;
      CH_O:     pat = 7'h3F;
      CH_P:     pat = 7'h73;
      CH_U:     pat = 7'h3E;
      CH_R:     pat = 7'h50;
      CH_DASH:  pat = 7'h40;
      default:  pat = 7'h00;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/alarm_msg_display_seg7_char_dec.sv
// Combinational character-code to active-high 7-segment decoder.
module seg7_char_dec
  import alarm_disp_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] pattern
);

  // Table lookup; unknown codes come back blank.
  always_comb begin
    pattern = char_segments(code);
  end

endmodule

// File: rtl/alarm_msg_display.sv
// N-digit 7-segment message engine: writable character buffer shown
// static, blinking or scrolling, stepped by an internal prescaler tick.
//
// Control interface: wr_en, start and stop are single-cycle strobes with
// no back-pressure; each is acted on at the rising edge where it is high.
// stop beats start, rst beats everything.
module alarm_msg_display
  import alarm_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int MSG_LEN    = 8,
  parameter int TICK_DIV   = 25_000_000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [$clog2(MSG_LEN)-1:0]     wr_addr,
  input  logic [4:0]                     wr_char,
  input  logic [$clog2(MSG_LEN+1)-1:0]   msg_len,
  input  logic [1:0]                     mode,
  input  logic                           start,
  input  logic                           stop,
  output logic                           busy,
  output logic [7*NUM_DIGITS-1:0]        seg
);

  localparam int AW = $clog2(MSG_LEN);
  localparam int LW = $clog2(MSG_LEN + 1);
  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int IW = $clog2(MSG_LEN + NUM_DIGITS + 1);
  localparam int SW = 7 * NUM_DIGITS;

  char_t            buffer [MSG_LEN];
  logic [1:0]       state;
  logic [1:0]       mode_q;
  logic [LW-1:0]    len_q;
  logic [LW-1:0]    offset;
  logic [CW-1:0]    cnt;
  logic             tick;
  logic [LW-1:0]    len_start;
  char_t            digit_code [NUM_DIGITS];
  logic [SW-1:0]    digit_pat;

  assign tick = (cnt == CW'(TICK_DIV - 1));

  // Buffer slot for digit i while scrolling: (off + i) mod len, done by
  // repeated subtraction since off + i never exceeds len + NUM_DIGITS - 2.
  function automatic logic [AW-1:0] scroll_addr(input logic [LW-1:0] off,
                                                 input logic [LW-1:0] len,
                                                 input int digit);
    logic [IW-1:0] v;
    v = IW'(off) + IW'(digit);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (v >= IW'(len)) v = v - IW'(len);
    end
    return v[AW-1:0];
  endfunction

  // Clamp requested length to 1..MSG_LEN for latching at start.
  always_comb begin
    len_start = msg_len;
    if (msg_len == '0) begin
      len_start = LW'(1);
    end else if (msg_len > LW'(MSG_LEN)) begin
      len_start = LW'(MSG_LEN);
    end
  end

  // Character buffer; out-of-range addresses match no slot and are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MSG_LEN; i++) buffer[i] <= CH_BLANK;
    end else begin
      for (int i = 0; i < MSG_LEN; i++) begin
        if (wr_en && (wr_addr == AW'(i))) buffer[i] <= wr_char;
      end
    end
  end

  // Display FSM with prescaler and scroll offset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      mode_q <= MODE_STATIC;
      len_q  <= LW'(1);
      offset <= '0;
      cnt    <= '0;
    end else if (stop) begin
      state  <= ST_IDLE;
      offset <= '0;
      cnt    <= '0;
    end else if (start) begin
      mode_q <= mode;
      len_q  <= len_start;
      offset <= '0;
      cnt    <= '0;
      state  <= (mode == MODE_SCROLL) ? ST_SCROLL : ST_SHOW_ON;
    end else begin
      if (state != ST_IDLE) cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        case (state)
          ST_SHOW_ON:  if (mode_q == MODE_BLINK) state <= ST_SHOW_OFF;
          ST_SHOW_OFF: state <= ST_SHOW_ON;
          ST_SCROLL:   offset <= (offset == len_q - 1'b1) ? '0 : offset + 1'b1;
          default:     ;
        endcase
      end
    end
  end

  // Pick the character each digit shows in the current state.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit_code[i] = CH_BLANK;
      case (state)
        ST_SHOW_ON: if (IW'(i) < IW'(len_q)) digit_code[i] = buffer[AW'(i)];
        ST_SCROLL:  digit_code[i] = buffer[scroll_addr(offset, len_q, i)];
        default:    ;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg7_char_dec u_dec (
      .code    (digit_code[g]),
      .pattern (digit_pat[7*g +: 7])
    );
  end

  // Registered outputs; polarity applied only here.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg  <= ACTIVE_LOW ? {SW{1'b1}} : {SW{1'b0}};
      busy <= 1'b0;
    end else begin
      seg  <= ACTIVE_LOW ? ~digit_pat : digit_pat;
      busy <= (state != ST_IDLE);
    end
  end

endmodule
